// File: rtl/pipe_stage_reg_if.sv
// Bundle of the hazard-unit controls, the incoming pipeline entry and the
// registered outputs of pipe_stage_reg.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int REG_W  = 5
);
  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] data1_i;
  logic [DATA_W-1:0] data2_i;
  logic [REG_W-1:0]  rd_i;
  logic              valid_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data1_o;
  logic [DATA_W-1:0] data2_o;
  logic [REG_W-1:0]  rd_o;
  logic [2:0]        occ_o;
  logic [15:0]       bubble_cnt_o;

  modport master (
    output stall_i, flush_i, valid_i, ctrl_i, data1_i, data2_i, rd_i,
    input  valid_o, ctrl_o, data1_o, data2_o, rd_o, occ_o, bubble_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, ctrl_i, data1_i, data2_i, rd_i,
    output valid_o, ctrl_o, data1_o, data2_o, rd_o, occ_o, bubble_cnt_o
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Configurable-depth inter-stage pipeline register with valid bits, stall,
// flush, occupancy and a saturating bubble counter.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int REG_W  = 5,
  parameter int STAGES = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  pipe_stage_reg_if.slave     bus
);

  generate
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("pipe_stage_reg: STAGES must be in 1..4");
    end
  endgenerate

  localparam int LAST = STAGES - 1;

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [REG_W-1:0]  rd;
  } entry_t;

  entry_t      stage_r     [STAGES];
  entry_t      stage_nxt_s [STAGES];
  entry_t      in_s;
  logic [2:0]  occ_r;
  logic [2:0]  occ_nxt_s;
  logic [15:0] bubble_r;
  logic [15:0] bubble_nxt_s;

  // Incoming entry with bubbles forced to all-zero so they never assert control downstream
  always_comb begin
    in_s = '0;
    if (bus.valid_i) begin
      in_s.valid = 1'b1;
      in_s.ctrl  = bus.ctrl_i;
      in_s.data1 = bus.data1_i;
      in_s.data2 = bus.data2_i;
      in_s.rd    = bus.rd_i;
    end else begin
      in_s = '0;
    end
  end

  // Next stage contents: flush beats stall, stall beats shift
  always_comb begin
    stage_nxt_s = stage_r;
    if (bus.flush_i) begin
      for (int s = 0; s < STAGES; s++) begin
        stage_nxt_s[s] = '0;
      end
    end else if (bus.stall_i) begin
      stage_nxt_s = stage_r;
    end else begin
      stage_nxt_s[0] = in_s;
      for (int s = 1; s < STAGES; s++) begin
        stage_nxt_s[s] = stage_r[s-1];
      end
    end
  end

  // Occupancy is counted on the next contents so it lands on the same edge
  always_comb begin
    occ_nxt_s = 3'd0;
    for (int s = 0; s < STAGES; s++) begin
      occ_nxt_s = occ_nxt_s + {2'b00, stage_nxt_s[s].valid};
    end
  end

  // Bubble counter looks at the pre-edge output valid and saturates
  always_comb begin
    bubble_nxt_s = bubble_r;
    if (!bus.stall_i && !stage_r[LAST].valid && (bubble_r != 16'hFFFF)) begin
      bubble_nxt_s = bubble_r + 16'd1;
    end else begin
      bubble_nxt_s = bubble_r;
    end
  end

  // State registers; reset overrides stall and flush
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < STAGES; s++) begin
        stage_r[s] <= '0;
      end
      occ_r    <= 3'd0;
      bubble_r <= 16'd0;
    end else begin
      stage_r  <= stage_nxt_s;
      occ_r    <= occ_nxt_s;
      bubble_r <= bubble_nxt_s;
    end
  end

  assign bus.valid_o      = stage_r[LAST].valid;
  assign bus.ctrl_o       = stage_r[LAST].ctrl;
  assign bus.data1_o      = stage_r[LAST].data1;
  assign bus.data2_o      = stage_r[LAST].data2;
  assign bus.rd_o         = stage_r[LAST].rd;
  assign bus.occ_o        = occ_r;
  assign bus.bubble_cnt_o = bubble_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: one-stage and three-stage instances driven in parallel,
// compared each cycle against a queue model plus directed literal checks.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, vin;
  logic [3:0]  ctrl;
  logic [31:0] d1, d2;
  logic [4:0]  rd;
  logic        chk_en = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(4), .REG_W(5)) bus1 ();
  pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(4), .REG_W(5)) bus3 ();

  assign bus1.stall_i = stall;  assign bus3.stall_i = stall;
  assign bus1.flush_i = flush;  assign bus3.flush_i = flush;
  assign bus1.valid_i = vin;    assign bus3.valid_i = vin;
  assign bus1.ctrl_i  = ctrl;   assign bus3.ctrl_i  = ctrl;
  assign bus1.data1_i = d1;     assign bus3.data1_i = d1;
  assign bus1.data2_i = d2;     assign bus3.data2_i = d2;
  assign bus1.rd_i    = rd;     assign bus3.rd_i    = rd;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .REG_W(5), .STAGES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1)
  );
  pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .REG_W(5), .STAGES(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .bus(bus3)
  );

  typedef struct packed {
    logic        v;
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  r;
  } ent_t;
  typedef ent_t ent_q_t[$];

  ent_q_t q1, q3;
  int     bub1 = 0;
  int     bub3 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: a queue of n entries, front = newest, back = visible output
  task automatic mdl_step(inout ent_q_t q, inout int bub, input int n);
    ent_t last, cap;
    if (rst) begin
      q.delete();
      for (int i = 0; i < n; i++) q.push_back('0);
      bub = 0;
    end else begin
      last = q[q.size()-1];
      if (!stall && !last.v) bub = (bub >= 65535) ? 65535 : bub + 1;
      if (flush) begin
        for (int i = 0; i < n; i++) q[i] = '0;
      end else if (!stall) begin
        cap = vin ? {1'b1, ctrl, d1, d2, rd} : '0;
        q.push_front(cap);
        void'(q.pop_back());
      end
    end
  endtask

  function automatic int occ_of(input ent_q_t q);
    int c = 0;
    foreach (q[i]) c += int'(q[i].v);
    return c;
  endfunction

  always @(posedge clk) begin
    mdl_step(q1, bub1, 1);
    mdl_step(q3, bub3, 3);
  end

  task automatic cmp_dut(input string tag, input logic v, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] r,
                         input logic [2:0] occ, input logic [15:0] bub,
                         input ent_q_t q, input int mbub);
    ent_t last;
    last = q[q.size()-1];
    chk({tag, "_valid"}, 64'(v), 64'(last.v));
    chk({tag, "_ctrl"}, 64'(c), 64'(last.c));
    chk({tag, "_data1"}, 64'(a), 64'(last.a));
    chk({tag, "_data2"}, 64'(b), 64'(last.b));
    chk({tag, "_rd"}, 64'(r), 64'(last.r));
    chk({tag, "_occ"}, 64'(occ), 64'(occ_of(q)));
    chk({tag, "_bubble"}, 64'(bub), 64'(mbub));
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut("m1", bus1.valid_o, bus1.ctrl_o, bus1.data1_o, bus1.data2_o, bus1.rd_o,
              bus1.occ_o, bus1.bubble_cnt_o, q1, bub1);
      cmp_dut("m3", bus3.valid_o, bus3.ctrl_o, bus3.data1_o, bus3.data2_o, bus3.rd_o,
              bus3.occ_o, bus3.bubble_cnt_o, q3, bub3);
    end
  end

  task automatic set_in(input logic v, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r);
    vin = v; ctrl = c; d1 = a; d2 = b; rd = r;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_in(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    step();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    chk("rst_valid1", 64'(bus1.valid_o), 64'd0);
    chk("rst_data2_1", 64'(bus1.data2_o), 64'd0);
    chk("rst_occ3", 64'(bus3.occ_o), 64'd0);
    chk("rst_bub3", 64'(bus3.bubble_cnt_o), 64'd0);

    // Single-stage capture
    set_in(1'b1, 4'b1010, 32'h0000_1234, 32'hDEAD_BEEF, 5'd7);
    chk("t1_pre_valid", 64'(bus1.valid_o), 64'd0);
    step();
    set_in(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    chk("t1_valid", 64'(bus1.valid_o), 64'd1);
    chk("t1_ctrl", 64'(bus1.ctrl_o), 64'hA);
    chk("t1_data1", 64'(bus1.data1_o), 64'h1234);
    chk("t1_data2", 64'(bus1.data2_o), 64'hDEAD_BEEF);
    chk("t1_rd", 64'(bus1.rd_o), 64'd7);
    chk("t1_occ", 64'(bus1.occ_o), 64'd1);
    chk("t1_bub", 64'(bus1.bubble_cnt_o), 64'd1);
    chk("t1_occ3", 64'(bus3.occ_o), 64'd1);

    // Three-stage stream of 5 entries, then drain
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      if (e <= 5) set_in(1'b1, 4'b0100, 32'(e), ~32'(e), 5'(e));
      else        set_in(1'b0, 4'b0100, 32'h0, 32'h0, 5'd0);
      step();
      chk($sformatf("t2_data1_e%0d", e), 64'(bus3.data1_o),
          (e >= 3 && e <= 7) ? 64'(e - 2) : 64'd0);
      chk($sformatf("t2_occ_e%0d", e), 64'(bus3.occ_o),
          (e <= 5) ? 64'((e < 3) ? e : 3) : 64'(8 - e));
    end

    // Stall for two cycles with three entries held
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      set_in(1'b1, 4'b1010, 32'(k), 32'h0, 5'(k));
      step();
    end
    stall = 1'b1;
    set_in(1'b1, 4'b1111, 32'd99, 32'h0, 5'd9);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("t3_stall_data1", 64'(bus3.data1_o), 64'd1);
      chk("t3_stall_occ", 64'(bus3.occ_o), 64'd3);
      chk("t3_stall_bub", 64'(bus3.bubble_cnt_o), 64'd3);
    end
    stall = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      if (r <= 2) set_in(1'b1, 4'b1010, 32'(r + 3), 32'h0, 5'(r + 3));
      else        set_in(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
      step();
      chk($sformatf("t3_resume_r%0d", r), 64'(bus3.data1_o), 64'(r + 1));
      chk("t3_resume_valid", 64'(bus3.valid_o), 64'd1);
    end

    // Stall and flush together with three valid entries
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      set_in(1'b1, 4'b1010, 32'(k), 32'h0, 5'(k));
      step();
    end
    stall = 1'b1; flush = 1'b1;
    step();
    stall = 1'b0; flush = 1'b0;
    chk("t4_valid", 64'(bus3.valid_o), 64'd0);
    chk("t4_ctrl", 64'(bus3.ctrl_o), 64'd0);
    chk("t4_occ", 64'(bus3.occ_o), 64'd0);
    chk("t4_bub", 64'(bus3.bubble_cnt_o), 64'd3);
    set_in(1'b1, 4'b0110, 32'd7, 32'h0, 5'd3);
    for (int f = 1; f <= 3; f++) begin
      step();
      set_in(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
      chk($sformatf("t4_post_valid_f%0d", f), 64'(bus3.valid_o), (f == 3) ? 64'd1 : 64'd0);
    end
    chk("t4_post_data1", 64'(bus3.data1_o), 64'd7);
    chk("t4_post_bub", 64'(bus3.bubble_cnt_o), 64'd6);

    // Bubble with ctrl forced to zero, then saturation of the counter
    do_reset();
    set_in(1'b0, 4'b1111, 32'h55, 32'h66, 5'd4);
    step();
    chk("t5_ctrl", 64'(bus1.ctrl_o), 64'd0);
    chk("t5_valid", 64'(bus1.valid_o), 64'd0);
    chk("t5_data1", 64'(bus1.data1_o), 64'd0);
    chk("t5_bub", 64'(bus1.bubble_cnt_o), 64'd1);
    repeat (65533) step();
    chk("t5_bub_fffe", 64'(bus1.bubble_cnt_o), 64'hFFFE);
    step();
    chk("t5_bub_ffff", 64'(bus1.bubble_cnt_o), 64'hFFFF);
    step();
    chk("t5_bub_sat1", 64'(bus1.bubble_cnt_o), 64'hFFFF);
    chk("t5_bub_sat3", 64'(bus3.bubble_cnt_o), 64'hFFFF);

    // Reset with stall mid-stream
    set_in(1'b1, 4'b1001, 32'd11, 32'd1, 5'd1);
    step();
    set_in(1'b1, 4'b1001, 32'd12, 32'd2, 5'd2);
    step();
    rst = 1'b1; stall = 1'b1;
    set_in(1'b1, 4'b1001, 32'd13, 32'd3, 5'd3);
    step();
    rst = 1'b0; stall = 1'b0;
    chk("t6_valid1", 64'(bus1.valid_o), 64'd0);
    chk("t6_data1_1", 64'(bus1.data1_o), 64'd0);
    chk("t6_occ3", 64'(bus3.occ_o), 64'd0);
    chk("t6_bub3", 64'(bus3.bubble_cnt_o), 64'd0);
    chk("t6_bub1", 64'(bus1.bubble_cnt_o), 64'd0);
    set_in(1'b1, 4'b0011, 32'd14, 32'd4, 5'd4);
    step();
    set_in(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    chk("t6_after_data1", 64'(bus1.data1_o), 64'd14);
    chk("t6_after_bub", 64'(bus1.bubble_cnt_o), 64'd1);
    chk("t6_after_occ3", 64'(bus3.occ_o), 64'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage CPU. It generalises the fixed EX/MEM latch to a configurable payload (control bits, two data words, destination register) and a configurable depth of 1..4 back-to-back stages. It adds a per-entry valid bit, stall (hold), flush (bubble insertion) and occupancy and bubble-statistics outputs. It sits between any two pipeline stages (ID/EX, EX/MEM, MEM/WB) and is driven by the hazard unit.

## Interface

Parameters:
- DATA_W, 32, width of each data word
- CTRL_W, 4, number of control bits (e.g. MemToReg, RegWrite, MemRead, MemWrite)
- REG_W, 5, destination register index width
- STAGES, 1, number of chained register stages; legal 1..4; any other value is a compile-time error

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  reset; synchronous, active-high
- stall_i  in  1  hold every stage's contents
- flush_i  in  1  invalidate every stage (insert bubbles)
- valid_i  in  1  incoming entry is a real instruction
- ctrl_i  in  CTRL_W  control bits of incoming entry
- data1_i  in  DATA_W  first data word (e.g. ALU result)
- data2_i  in  DATA_W  second data word (e.g. store data)
- rd_i  in  REG_W  destination register index
- valid_o  out  1  valid bit of the last stage
- ctrl_o  out  CTRL_W  control bits of the last stage
- data1_o  out  DATA_W  first data word of the last stage
- data2_o  out  DATA_W  second data word of the last stage
- rd_o  out  REG_W  destination register index of the last stage
- occ_o  out  3  number of valid entries currently held, 0..STAGES
- bubble_cnt_o  out  16  saturating count of cycles in which valid_o=0 and stall_i=0

## Operation

- Each stage s holds {valid, ctrl, data1, data2, rd}. Stage 0 loads from the inputs. Stage s loads from stage s-1. Outputs come from stage STAGES-1.
- Bubble rule: whenever an entry is written with valid=0 (from valid_i=0, flush or reset), its ctrl field is written as all-zero. An invalid entry therefore never asserts RegWrite or MemWrite downstream. data1, data2 and rd of an invalid entry are don't-care, but the design writes them as zero.
- Priority, highest first, evaluated per edge:
  - rst_i: all stages cleared (valid=0, all fields 0); occ_o=0; bubble_cnt_o=0.
  - flush_i: all stages get valid=0 and ctrl=0. Data fields are zeroed. The incoming entry is discarded. bubble_cnt_o updates per its own rule.
  - stall_i: all stages hold their value. The incoming entry is not captured. bubble_cnt_o holds.
  - Otherwise: shift by one stage; stage 0 captures the inputs, with the bubble rule applied.
- A stall and a flush in the same cycle resolve to flush.
- occ_o is the registered count of valid bits across all stages. It is updated in the same edge as the stages, so it always matches the current stage contents.
- bubble_cnt_o increments by 1 on each edge where the pre-edge valid_o=0 and stall_i=0 and rst_i=0. It saturates at 16'hFFFF and does not wrap.

## Timing

- Latency from input to output is STAGES rising edges, with no stall.
- Each stalled cycle adds exactly one cycle of latency.
- A flush asserted at edge N makes valid_o=0 and ctrl_o=0 visible immediately after edge N. The first post-flush entry appears STAGES edges after it is presented.
- Reset values of all outputs are 0: valid_o, ctrl_o, data1_o, data2_o, rd_o, occ_o, bubble_cnt_o.
- After rst_i deasserts, the block operates normally from the next edge.
- A reset asserted mid-stream discards every in-flight entry on that edge, regardless of stall_i or flush_i.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Full condition is occ_o=STAGES. There is no backpressure output: the block never drops an entry except on flush or reset. Holding entries is the hazard unit's responsibility via stall_i.

## Test plan

- STAGES=1, reset, then present valid=1, ctrl=4'b1010, data1=32'h0000_1234, data2=32'hDEAD_BEEF, rd=5'd7 -> after 1 edge the outputs equal the inputs and occ_o=1. Before that edge, all outputs are 0.
- STAGES=3: stream 5 entries with data1=1..5 -> data1_o shows 1..5 on edges 3..7 and occ_o reaches 3. Drop valid_i afterwards -> occ_o falls 3,2,1,0.
- STAGES=3: assert stall_i for 2 cycles while holding entries 1,2,3 -> outputs frozen and occ_o=3 throughout. After release, the stream resumes with no loss or duplication.
- Assert stall_i and flush_i together while 3 entries are valid -> next edge: valid_o=0, ctrl_o=0, occ_o=0.
- valid_i=0 with ctrl_i=4'b1111 -> captured entry has ctrl_o=4'b0000 and valid_o=0. bubble_cnt_o increments once per non-stalled cycle with valid_o=0. Preload to 16'hFFFE via 65534 idle cycles -> it saturates at 16'hFFFF.
- Assert rst_i mid-stream together with stall_i -> on the next edge all outputs are 0 and bubble_cnt_o=0.
